// File: rtl/param_streamer_pkg.sv
// -----------------------------------------------------------------------------
// param_streamer_pkg
// Shared definitions for the parameter streamer and its address counter:
//   - state_e       : streamer FSM states (IDLE, RUN, DONE)
//   - DEF_ROWS/COLS : default matrix geometry
//   - DEF_DW        : default parameter word width
//   - ROW_AW/COL_AW : fixed widths of the store row/column address ports
// -----------------------------------------------------------------------------
package param_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_ROWS = 2;
    localparam int DEF_COLS = 4;
    localparam int DEF_DW   = 16;

    localparam int ROW_AW = 2;
    localparam int COL_AW = 4;

endpackage

// File: rtl/param_addr_counter.sv
// -----------------------------------------------------------------------------
// param_addr_counter
// Row-major (column inner, row outer) address counter over a ROWS x COLS
// matrix. Advancing past the final element wraps both counters back to 0.
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset (counters to 0)
//   clear    in   force counters to 0
//   advance  in   step to the next element
//   row      out  current row address
//   col      out  current column address
//   last     out  counters sit on the final element (ROWS-1, COLS-1)
// -----------------------------------------------------------------------------
module param_addr_counter
    import param_streamer_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [ROW_AW-1:0] row,
    output logic [COL_AW-1:0] col,
    output logic              last
);

    localparam logic [ROW_AW-1:0] ROW_MAX = ROW_AW'(ROWS - 1);
    localparam logic [COL_AW-1:0] COL_MAX = COL_AW'(COLS - 1);

    logic [ROW_AW-1:0] row_q, row_d;
    logic [COL_AW-1:0] col_q, col_d;

    always_comb begin
        // NOTE: defaults first so every path assigns row_d/col_d; otherwise a latch is inferred.
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so all registers update together.
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/param_streamer.sv
// -----------------------------------------------------------------------------
// param_streamer
// Streams a ROWS x COLS parameter matrix, row-major, from a combinational
// parameter store onto a valid/ready output, one word per cycle when the
// consumer is always ready. A one-cycle done pulse follows the last accepted
// word.
//
// Optional feature (macro PARAM_STREAMER_CHECKSUM_EN): adds a DW-bit checksum
// output, the modulo-2^DW sum of all accepted words since the last start.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset, priority over start
//   start      in   one-cycle request, honoured only in IDLE
//   sel_i      out  store row address (row counter)
//   sel_j      out  store column address (column counter)
//   param_in   in   store read data at (sel_i, sel_j)
//   out_data   out  streamed word
//   out_valid  out  out_data holds a word not yet accepted
//   out_ready  in   consumer accept
//   out_last   out  final word of the matrix
//   busy       out  FSM outside IDLE; store must not be written
//   done       out  one-cycle pulse after the last word is accepted
//   checksum   out  (PARAM_STREAMER_CHECKSUM_EN only) running word sum
// -----------------------------------------------------------------------------
module param_streamer
    import param_streamer_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int DW   = DEF_DW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ROW_AW-1:0] sel_i,
    output logic [COL_AW-1:0] sel_j,
    input  logic [DW-1:0]     param_in,
    output logic [DW-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef PARAM_STREAMER_CHECKSUM_EN
    ,
    output logic [DW-1:0]     checksum
`endif
);

    state_e          state_q;
    logic [DW-1:0]   out_data_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic            done_q;
    logic            words_left_q;  // at least one matrix element not yet loaded

    logic            stage_free;
    logic            start_accept;
    logic            advance;
    logic            cnt_last;

    assign stage_free   = !out_valid_q || out_ready;
    assign start_accept = (state_q == IDLE) && start;
    assign advance      = (state_q == RUN) && stage_free && words_left_q;

    param_addr_counter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_addr (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_accept),
        .advance (advance),
        .row     (sel_i),
        .col     (sel_j),
        .last    (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
            words_left_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= RUN;
                        words_left_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (stage_free) begin
                        if (words_left_q) begin
                            out_data_q  <= param_in;
                            out_valid_q <= 1'b1;
                            out_last_q  <= cnt_last;
                            // The counter wraps to (0,0) on this advance, so the
                            // flag is the only record that the matrix is exhausted.
                            if (cnt_last) begin
                                words_left_q <= 1'b0;
                            end
                        end else begin
                            // Stage is free, so the last word has just been accepted.
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

`ifdef PARAM_STREAMER_CHECKSUM_EN
    logic [DW-1:0] checksum_q;

    // Sum wraps naturally at DW bits; it freezes once streaming ends because
    // no further handshakes occur until the next start clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else if (start_accept) begin
            checksum_q <= '0;
        end else if (out_valid_q && out_ready) begin
            checksum_q <= checksum_q + out_data_q;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: doc/param_streamer.md
PARAM_STREAMER -- requirements
Module: param_streamer

Interface
REQ-001 The block SHALL have parameter ROWS, default 2, meaning the number of matrix rows to stream.
REQ-002 The block SHALL have parameter COLS, default 4, meaning the number of matrix columns to stream.
REQ-003 The block SHALL have parameter DW, default 16, meaning the parameter word width.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to stream the full matrix.
REQ-007 sel_i  output  2  row address driven to the parameter store read port.
REQ-008 sel_j  output  4  column address driven to the parameter store read port.
REQ-009 param_in  input  DW  combinational read data from the store at (sel_i, sel_j).
REQ-010 out_data  output  DW  streamed parameter word.
REQ-011 out_valid  output  1  out_data holds a word not yet accepted.
REQ-012 out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high.
REQ-013 out_last  output  1  marks the final word (row ROWS-1, col COLS-1).
REQ-014 busy  output  1  high outside IDLE; the host SHALL NOT write the store while busy.
REQ-015 done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 In IDLE, start=1 SHALL move to RUN and clear the row and column counters to 0; start SHALL be ignored in RUN and DONE.
REQ-018 sel_i/sel_j SHALL equal the row/column counters combinationally.
  - Counters are 0 in IDLE.
  - Order is row-major: column inner, row outer.
REQ-019 The output stage is free when out_valid=0 or out_ready=1.
  - In RUN, with words remaining and the stage free: out_data<=param_in, out_valid<=1, out_last<=(counter at last element), counters advance.
REQ-020 The column counter SHALL wrap from COLS-1 to 0 and increment the row; after (ROWS-1, COLS-1) no words remain.
REQ-021 In RUN, with no words remaining and the stage free: out_valid<=0, out_last<=0, state<=DONE.
REQ-022 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_last and the counters SHALL hold.
REQ-024 Throughput SHALL be one word per cycle with out_ready held high.
  - start sampled at edge 0 gives words at cycles 1..ROWS*COLS and done at cycle ROWS*COLS+1.
REQ-025 out_valid SHALL NOT drop until its word is accepted.

Reset
REQ-026 reset SHALL return the block to IDLE on the next edge from any state, including mid-stream, and SHALL discard any pending word.
REQ-027 Reset values SHALL be:
  - out_valid=0, out_last=0, out_data=0, done=0, busy=0, sel_i=0, sel_j=0.
REQ-028 reset SHALL take priority over start.

Configuration
REQ-029 With PARAM_STREAMER_CHECKSUM_EN defined, the block SHALL add output checksum (DW bits) as follows:
  - checksum is cleared on start.
  - Each accepted out_data is added to it modulo 2^DW.
  - Its value is held from the done cycle until the next start or reset.
REQ-030 Without PARAM_STREAMER_CHECKSUM_EN, the checksum port and adder SHALL be absent; all other behaviour is identical.

Structure
REQ-031 A shared package SHALL hold:
  - the state enum (IDLE, RUN, DONE);
  - default ROWS/COLS/DW constants;
  - address widths 2 and 4.
REQ-032 The row/column counter SHALL be one sub-module, param_addr_counter, with inputs clear and advance and outputs row, col and last.

Verification
REQ-033 Store the value 0x1000+8*i+j at each address; start with out_ready=1 -> 8 words 0x1000,0x1001..0x1003,0x1008..0x100B on cycles 1-8, out_last only on 0x100B, done on cycle 9.
REQ-034 Same store, out_ready low for cycles 3-5 -> out_data holds 0x1002 with out_valid=1 through cycle 5; order is unchanged; done is delayed 3 cycles.
REQ-035 start pulsed again at cycle 4 -> ignored; exactly 8 words are output and one done pulse.
REQ-036 reset asserted at cycle 5 -> next cycle out_valid=0, busy=0, sel_i=0, sel_j=0 and no done; a new start streams from 0x1000.
REQ-037 With PARAM_STREAMER_CHECKSUM_EN, store all words 0xFFFF -> checksum=0xFFF8 at done (wrap-around); with ready stalls inserted -> same value.
REQ-038 out_ready=0 at the moment of the last word -> out_last holds with out_valid; done fires one cycle after acceptance.
